sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Command scheduler sitting between the SDRAM init/refresh/write/read sub-FSMs and the shared SDRAM command bus inside SDRAM_TOP.
- Owns the auto-refresh interval timer.
- Grants the bus to exactly one of refresh, write burst or read burst at a time.
- Generates linear burst base addresses for the write and read FIFO paths, so SDRAM behaves as a circular buffer.

Parameters:
REF_CYCLES, 780, sysclk_100M cycles between refresh requests (7.8 us at 100 MHz)
BURST_LEN, 8, words per write/read burst; power of two
ADDR_W, 24, linear word address width ({ba[1:0], row[12:0], col[8:0]})

Ports:
sysclk_100M  in   1       single clock for the whole block
rst          in   1       asynchronous, active-high reset
init_done    in   1       level; high once the power-up init sequence has completed
wr_req       in   1       level; write FIFO holds >= BURST_LEN words
rd_req       in   1       level; read FIFO has room for >= BURST_LEN words
ref_end      in   1       1-cycle pulse; refresh sub-FSM finished
wr_end       in   1       1-cycle pulse; write burst finished
rd_end       in   1       1-cycle pulse; read burst finished
ref_en       out  1       1-cycle grant pulse to the refresh sub-FSM
wr_en        out  1       1-cycle grant pulse to the write sub-FSM
rd_en        out  1       1-cycle grant pulse to the read sub-FSM
wr_addr      out  ADDR_W  base address of the next/current write burst
rd_addr      out  ADDR_W  base address of the next/current read burst
busy         out  1       high in AREF, WRITE or READ
full         out  1       high when stored bursts equal capacity (2^ADDR_W/BURST_LEN)

Behaviour:
- Reset values: state IDLE; all outputs 0; ref timer 0; ref_pend 0; pending burst count 0; last_served = READ.
- States: IDLE, ARBIT, AREF, WRITE, READ.
- IDLE -> ARBIT on the first cycle init_done is sampled high.
- ARBIT, evaluated each cycle in this priority order:
  - ref_pend -> AREF.
  - Else wr_ok and rd_ok both true -> go to the opposite of last_served.
  - Else whichever of wr_ok / rd_ok is true.
  - Else stay in ARBIT.
  - wr_ok = wr_req & !full.
  - rd_ok = rd_req & (pending != 0).
- Grant timing: the grant pulse (ref_en / wr_en / rd_en) is registered. It is high on the first cycle in the new state only, so it appears one cycle after the decision cycle.
- AREF -> ARBIT on ref_end. Clears ref_pend in the same cycle ref_en is asserted.
- WRITE -> ARBIT on wr_end:
  - wr_addr += BURST_LEN, wrapping mod 2^ADDR_W.
  - pending += 1.
  - last_served = WRITE.
- READ -> ARBIT on rd_end:
  - rd_addr += BURST_LEN, wrapping.
  - pending -= 1.
  - last_served = READ.
- End pulses are ignored in any state other than their own; no counter changes on a stray pulse.
- Refresh timer:
  - Counts only while init_done is high.
  - At REF_CYCLES-1 it reloads to 0 and sets ref_pend.
- Refresh deferral:
  - A refresh falling due during WRITE/READ waits; the burst is never pre-empted.
  - AREF is entered on the cycle after the burst returns to ARBIT.
  - A second timer expiry while ref_pend is already set leaves ref_pend at 1; refreshes are not queued.
  - If ref_pend is being cleared by a grant in the same cycle the timer expires, set wins.
- Address/count widths:
  - The pending counter is ADDR_W-log2(BURST_LEN)+1 bits wide.
  - full = pending == 2^(ADDR_W-log2(BURST_LEN)).
  - wr_addr/rd_addr low log2(BURST_LEN) bits are always 0.
- busy is combinational from state.
- full is registered, updated with pending.
- init_done falling outside IDLE: the block finishes the current grant and returns to ARBIT. It stays in ARBIT with the timer frozen and no new grants until init_done rises again.
- rst asserted mid-burst:
  - All registers return to reset values immediately (asynchronous).
  - Grant outputs drop at once.
  - Sub-FSMs are reset by the same rst.

Decomposition:
- Shared package sdram_pkg holds:
  - State encodings (IDLE/ARBIT/AREF/WRITE/READ, one-hot, 5 bits).
  - Default REF_CYCLES, BURST_LEN and ADDR_W constants, shared with the init/refresh/write/read sub-FSMs.
- One natural sub-module, sdram_ref_timer: the interval counter plus the ref_pend set/clear logic. The arbiter FSM, address counters and pending counter stay in sdram_arbiter.

Test Plan:
- Reset with REF_CYCLES=20, init_done held 0 for 100 cycles:
  - No grants; state IDLE; timer 0.
  - Raise init_done: first ref_en exactly 21 cycles later.
- wr_req=1, rd_req=0, ref_end/wr_end returned 4 cycles after each grant:
  - Repeated wr_en pulses.
  - wr_addr steps 0, 8, 16, ...
  - rd_en never asserted while pending=0.
- After 3 writes, wr_req=rd_req=1:
  - Grants alternate read, write, read, ...
  - rd_addr 0, 8, 16.
  - pending oscillates between 3 and 2.
- Timer expires two cycles into a write burst:
  - Write completes.
  - ref_en appears the cycle after ARBIT is re-entered.
  - Write and read both requested → refresh granted first.
- ADDR_W=6, BURST_LEN=8, writes only:
  - After 8 bursts full=1 and wr_en stops.
  - wr_addr wraps to 0.
  - One read clears full and the next write is granted.
- Assert rst mid-WRITE (before wr_end):
  - All outputs 0 asynchronously; wr_addr=0; pending=0.
  - After release, the FSM waits for init_done in IDLE.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: arbiter state encoding and
// default timing/geometry constants used by the arbiter and its sub-FSMs.
package sdram_pkg;

  localparam int REF_CYCLES_DEF = 780;
  localparam int BURST_LEN_DEF  = 8;
  localparam int ADDR_W_DEF     = 24;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ARBIT = 5'b00010,
    AREF  = 5'b00100,
    WRITE = 5'b01000,
    READ  = 5'b10000
  } state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises ref_pend every REF_CYCLES cycles of
// init_done and holds it until the refresh grant clears it.
module sdram_ref_timer import sdram_pkg::*; #(
  parameter int REF_CYCLES = REF_CYCLES_DEF
) (
  input  logic sysclk_100M,
  input  logic rst,
  input  logic init_done,
  input  logic ref_clr,
  output logic ref_pend
);

  localparam int CNT_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

  logic [CNT_W-1:0] count;
  logic             expire;

  assign expire = init_done && (count == CNT_W'(REF_CYCLES - 1));

  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      count    <= '0;
      ref_pend <= 1'b0;
    end else begin
      if (init_done)
        count <= expire ? '0 : count + CNT_W'(1);
      // A fresh expiry outranks a simultaneous clear so no refresh is lost.
      if (expire)
        ref_pend <= 1'b1;
      else if (ref_clr)
        ref_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: schedules refresh, write and read bursts and
// keeps circular-buffer write/read base addresses plus a stored-burst count.
module sdram_arbiter import sdram_pkg::*; #(
  parameter int REF_CYCLES = REF_CYCLES_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              sysclk_100M,
  input  logic              rst,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              ref_end,
  input  logic              wr_end,
  input  logic              rd_end,
  output logic              ref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              full
);

  localparam int OFS_W  = $clog2(BURST_LEN);
  localparam int PEND_W = ADDR_W - OFS_W + 1;
  localparam logic [PEND_W-1:0] CAP  = {1'b1, {(PEND_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN);

  state_t            state;
  logic [PEND_W-1:0] pending;
  logic              last_wr;
  logic              ref_pend;
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = wr_req && !full;
  assign rd_ok = rd_req && (pending != '0);
  assign busy  = (state == AREF) || (state == WRITE) || (state == READ);

  sdram_ref_timer #(
    .REF_CYCLES(REF_CYCLES)
  ) u_ref_timer (
    .sysclk_100M(sysclk_100M),
    .rst        (rst),
    .init_done  (init_done),
    .ref_clr    (ref_en),
    .ref_pend   (ref_pend)
  );

  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ref_en  <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      pending <= '0;
      full    <= 1'b0;
      last_wr <= 1'b0;
    end else begin
      ref_en <= 1'b0;
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (init_done)
            state <= ARBIT;
        end
        ARBIT: begin
          // When both bursts are eligible, serve the one not served last.
          if (init_done) begin
            if (ref_pend) begin
              state  <= AREF;
              ref_en <= 1'b1;
            end else if (wr_ok && (!rd_ok || !last_wr)) begin
              state <= WRITE;
              wr_en <= 1'b1;
            end else if (rd_ok) begin
              state <= READ;
              rd_en <= 1'b1;
            end
          end
        end
        AREF: begin
          if (ref_end)
            state <= ARBIT;
        end
        WRITE: begin
          if (wr_end) begin
            state   <= ARBIT;
            wr_addr <= wr_addr + STEP;
            pending <= pending + PEND_W'(1);
            full    <= (pending + PEND_W'(1)) == CAP;
            last_wr <= 1'b1;
          end
        end
        READ: begin
          if (rd_end) begin
            state   <= ARBIT;
            rd_addr <= rd_addr + STEP;
            pending <= pending - PEND_W'(1);
            full    <= 1'b0;
            last_wr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
